// File: rtl/conv_seq.sv
// conv_seq: walks a stride-1 output map, issues input/weight/bias read addresses and the aligned conv_unit control stream.
module conv_seq #(
    parameter int MEM_SIZE = 16,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int CH       = 1,
    parameter int K        = 3,
    parameter int OUT_CH   = 1,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 0,
    parameter int B_BASE   = 0,
    parameter int OUT_BASE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [MEM_SIZE-1:0] in_ra,
    output logic [MEM_SIZE-1:0] w_ra,
    output logic [MEM_SIZE-1:0] b_ra,
    output logic                unit_en,
    output logic                unit_set_b,
    output logic [MEM_SIZE-1:0] unit_out_wa
);
    typedef logic [MEM_SIZE-1:0] addr_t;
    typedef enum logic [2:0] {IDLE, RUN, BIAS, DRAIN, DONE} state_t;
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam addr_t ONE = addr_t'(1);
    localparam addr_t KA  = addr_t'(K);
    localparam addr_t K1  = addr_t'(K - 1);
    localparam addr_t CHA = addr_t'(CH);
    localparam addr_t CH1 = addr_t'(CH - 1);
    localparam addr_t IWA = addr_t'(IMG_W);
    localparam addr_t IHA = addr_t'(IMG_H);
    localparam addr_t OWA = addr_t'(OW);
    localparam addr_t OW1 = addr_t'(OW - 1);
    localparam addr_t OHA = addr_t'(OH);
    localparam addr_t OH1 = addr_t'(OH - 1);
    localparam addr_t OC1 = addr_t'(OUT_CH - 1);
    localparam addr_t INB = addr_t'(IN_BASE);
    localparam addr_t WB  = addr_t'(W_BASE);
    localparam addr_t BB  = addr_t'(B_BASE);
    localparam addr_t OB  = addr_t'(OUT_BASE);

    state_t     state, n_state;
    addr_t      kx, ky, c, ox, oy, oc;
    addr_t      n_kx, n_ky, n_c, n_ox, n_oy, n_oc;
    addr_t      in_n, w_n, out_n;
    logic [1:0] dcnt;
    logic       run, bias, kx_w, ky_w, c_w, ox_w, oy_w, oc_w, tap_last, out_last;

    // Addresses are computed from the next counters so they leave the register in the same cycle as their state.
    always_comb begin
        run      = state == RUN;
        bias     = state == BIAS;
        kx_w     = kx == K1;
        ky_w     = ky == K1;
        c_w      = c == CH1;
        ox_w     = ox == OW1;
        oy_w     = oy == OH1;
        oc_w     = oc == OC1;
        tap_last = kx_w && ky_w && c_w;
        out_last = ox_w && oy_w && oc_w;
        n_kx     = run ? (kx_w ? '0 : kx + ONE) : kx;
        n_ky     = run && kx_w ? (ky_w ? '0 : ky + ONE) : ky;
        n_c      = run && kx_w && ky_w ? (c_w ? '0 : c + ONE) : c;
        n_ox     = bias ? (ox_w ? '0 : ox + ONE) : ox;
        n_oy     = bias && ox_w ? (oy_w ? '0 : oy + ONE) : oy;
        n_oc     = bias && ox_w && oy_w ? (oc_w ? '0 : oc + ONE) : oc;
        n_state  = state == IDLE  ? (start ? RUN : IDLE) :
                   state == RUN   ? (tap_last ? BIAS : RUN) :
                   state == BIAS  ? (out_last ? DRAIN : RUN) :
                   state == DRAIN ? (dcnt == 2'd3 ? DONE : DRAIN) : IDLE;
        in_n     = INB + (n_c * IHA + n_oy + n_ky) * IWA + n_ox + n_kx;
        w_n      = WB + ((n_oc * CHA + n_c) * KA + n_ky) * KA + n_kx;
        out_n    = OB + (oc * OHA + oy) * OWA + ox;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            kx          <= '0;
            ky          <= '0;
            c           <= '0;
            ox          <= '0;
            oy          <= '0;
            oc          <= '0;
            dcnt        <= '0;
            in_ra       <= '0;
            w_ra        <= '0;
            b_ra        <= '0;
            unit_en     <= 1'b0;
            unit_set_b  <= 1'b0;
            unit_out_wa <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= n_state;
            kx          <= n_kx;
            ky          <= n_ky;
            c           <= n_c;
            ox          <= n_ox;
            oy          <= n_oy;
            oc          <= n_oc;
            dcnt        <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
            if (n_state == RUN) begin
                in_ra <= in_n;
                w_ra  <= w_n;
            end
            if (n_state == BIAS)
                b_ra <= BB + n_oc;
            // Control trails its address issue by one cycle to meet the synchronous read data.
            unit_en     <= run || bias;
            unit_set_b  <= bias;
            unit_out_wa <= bias ? out_n : '0;
            busy        <= n_state != IDLE;
            done        <= n_state == DONE;
        end
    end
endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: scoreboard bench driving two conv_seq configurations with directed passes.
module tb_conv_seq;
    typedef struct {
        bit bias;
        int ina;
        int wa;
        int ba;
        int owa;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic        en    [2];
    logic        sb    [2];
    logic [15:0] in_ra [2];
    logic [15:0] w_ra  [2];
    logic [15:0] b_ra  [2];
    logic [15:0] owa   [2];

    int   checks = 0;
    int   errors = 0;
    rec_t q       [2][$];
    int   tap_in  [2][$];
    int   tap_w   [2][$];
    int   bias_b  [2][$];
    int   bias_wa [2][$];
    int   exp_in  [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    always #5 clk = ~clk;

    conv_seq #(.MEM_SIZE(16), .IMG_W(4), .IMG_H(4), .CH(1), .K(3), .OUT_CH(1),
               .IN_BASE(0), .W_BASE(0), .B_BASE(0), .OUT_BASE(0)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .in_ra(in_ra[0]), .w_ra(w_ra[0]), .b_ra(b_ra[0]),
        .unit_en(en[0]), .unit_set_b(sb[0]), .unit_out_wa(owa[0]));

    conv_seq #(.MEM_SIZE(16), .IMG_W(3), .IMG_H(3), .CH(2), .K(2), .OUT_CH(2),
               .IN_BASE(100), .W_BASE(0), .B_BASE(50), .OUT_BASE(200)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .in_ra(in_ra[1]), .w_ra(w_ra[1]), .b_ra(b_ra[1]),
        .unit_en(en[1]), .unit_set_b(sb[1]), .unit_out_wa(owa[1]));

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d", nm, g, act, exp);
        end
    endtask

    task automatic push_pass(input int g);
        int w, k, ch, noc, ib, bb, ob, o;
        rec_t r;
        w   = g ? 3 : 4;
        k   = g ? 2 : 3;
        ch  = g ? 2 : 1;
        noc = g ? 2 : 1;
        ib  = g ? 100 : 0;
        bb  = g ? 50 : 0;
        ob  = g ? 200 : 0;
        o   = w - k + 1;
        for (int f = 0; f < noc; f++)
            for (int y = 0; y < o; y++)
                for (int x = 0; x < o; x++) begin
                    for (int ci = 0; ci < ch; ci++)
                        for (int j = 0; j < k; j++)
                            for (int i = 0; i < k; i++) begin
                                r.bias = 0;
                                r.ina  = ib + (ci * w + y + j) * w + x + i;
                                r.wa   = ((f * ch + ci) * k + j) * k + i;
                                r.ba   = 0;
                                r.owa  = 0;
                                q[g].push_back(r);
                            end
                    r.bias = 1;
                    r.ina  = 0;
                    r.wa   = 0;
                    r.ba   = bb + f;
                    r.owa  = ob + (f * o + y) * o + x;
                    q[g].push_back(r);
                end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        logic [15:0] p_in = '0;
        logic [15:0] p_w  = '0;
        logic [15:0] p_b  = '0;
        logic        p_sb = 1'b0;
        rec_t        r;
        always @(negedge clk) begin
            if (!rst) begin
                if (en[g]) begin
                    if (q[g].size() == 0)
                        chk("en_unexpected", g, int'(en[g]), 0);
                    else begin
                        r = q[g].pop_front();
                        chk("set_b", g, int'(sb[g]), int'(r.bias));
                        if (r.bias) begin
                            chk("b_ra", g, int'(p_b), r.ba);
                            chk("out_wa", g, int'(owa[g]), r.owa);
                            bias_b[g].push_back(int'(p_b));
                            bias_wa[g].push_back(int'(owa[g]));
                        end else begin
                            chk("in_ra", g, int'(p_in), r.ina);
                            chk("w_ra", g, int'(p_w), r.wa);
                            chk("out_wa_tap", g, int'(owa[g]), 0);
                            tap_in[g].push_back(int'(p_in));
                            tap_w[g].push_back(int'(p_w));
                        end
                    end
                end
                if (sb[g])
                    chk("set_b_consec", g, int'(p_sb), 0);
                if (!busy[g])
                    chk("idle_en", g, int'(en[g]), 0);
            end
            p_in = in_ra[g];
            p_w  = w_ra[g];
            p_b  = b_ra[g];
            p_sb = sb[g];
        end
    end

    task automatic run_pass(input int g, input int iss, input bit poke);
        int n;
        bit got;
        push_pass(g);
        tap_in[g].delete();
        tap_w[g].delete();
        bias_b[g].delete();
        bias_wa[g].delete();
        @(negedge clk);
        start[g] = 1'b1;
        n   = 0;
        got = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            start[g] = poke && n == 9;
            n++;
            if (n == 1)
                chk("busy_after_start", g, int'(busy[g]), 1);
            if (n >= iss + 2 && n <= iss + 4)
                chk("drain_en", g, int'(en[g]), 0);
            if (done[g]) begin
                got = 1;
                chk("done_cycle", g, n, iss + 5);
            end
        end
        chk("done_seen", g, int'(got), 1);
        start[g] = poke;
        @(negedge clk);
        start[g] = 1'b0;
        chk("done_width", g, int'(done[g]), 0);
        chk("busy_end", g, int'(busy[g]), 0);
        chk("queue_drained", g, q[g].size(), 0);
    endtask

    initial begin
        int lo, hi, nd;
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ra", 0, int'(in_ra[0]), 0);
        chk("rst_busy", 0, int'(busy[0]), 0);
        chk("rst_done", 0, int'(done[0]), 0);
        chk("rst_en", 1, int'(en[1]), 0);
        rst = 1'b0;

        run_pass(0, 40, 1'b1);
        for (int i = 0; i < 9; i++)
            chk("in_ra_out1", i, tap_in[0][9 + i], exp_in[i]);
        chk("writes_a", 0, bias_wa[0].size(), 4);
        for (int i = 0; i < 4; i++)
            chk("out_wa_a", i, bias_wa[0][i], i);
        run_pass(0, 40, 1'b0);
        chk("writes_a_again", 0, bias_wa[0].size(), 4);

        run_pass(1, 72, 1'b0);
        chk("writes_b", 1, bias_wa[1].size(), 8);
        chk("taps_b", 1, tap_w[1].size(), 64);
        lo = 999;
        hi = -1;
        for (int i = 32; i < 64; i++) begin
            lo = tap_w[1][i] < lo ? tap_w[1][i] : lo;
            hi = tap_w[1][i] > hi ? tap_w[1][i] : hi;
        end
        chk("w_ra_oc1_min", 1, lo, 8);
        chk("w_ra_oc1_max", 1, hi, 15);
        for (int i = 0; i < 8; i++) begin
            chk("b_ra_b", i, bias_b[1][i], i < 4 ? 50 : 51);
            chk("out_wa_b", i, bias_wa[1][i], 200 + i);
        end

        push_pass(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ra", 0, int'(in_ra[0]), 0);
        chk("abort_w_ra", 0, int'(w_ra[0]), 0);
        chk("abort_b_ra", 0, int'(b_ra[0]), 0);
        chk("abort_en", 0, int'(en[0]), 0);
        chk("abort_set_b", 0, int'(sb[0]), 0);
        chk("abort_out_wa", 0, int'(owa[0]), 0);
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_done", 0, int'(done[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        q[0].delete();
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            nd += int'(done[0]);
        end
        chk("no_done_after_abort", 0, nd, 0);
        chk("idle_after_abort", 0, int'(busy[0]), 0);

        run_pass(0, 40, 1'b0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
